// File: rtl/bbox_batch_ctrl.sv
// Batch sequencer for a single boundingBox engine. It walks NUM_IMAGES images packed in shared
// memory, relocates the engine's reads and hands pixel-unit results downstream over valid/ready.
module bbox_batch_ctrl #(
    parameter int WIDTH      = 100,
    parameter int HEIGHT     = 100,
    parameter int NUM_IMAGES = 4,
    parameter int IMG_WORDS  = WIDTH * HEIGHT * 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        batch_start,
    output logic        batch_busy,
    output logic        batch_done,
    output logic        eng_start,
    input  logic        eng_done,
    input  logic [23:0] eng_addr,
    input  logic [10:0] eng_xMin,
    input  logic [10:0] eng_xMax,
    input  logic [10:0] eng_yMin,
    input  logic [10:0] eng_yMax,
    output logic [23:0] mem_addr,
    input  logic [7:0]  mem_rddata,
    output logic [7:0]  eng_rddata,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  res_index,
    output logic [10:0] res_xMin,
    output logic [10:0] res_xMax,
    output logic [10:0] res_yMin,
    output logic [10:0] res_yMax,
    output logic [10:0] res_w,
    output logic [10:0] res_h,
    output logic        res_empty
);

    localparam logic [23:0] IMG_STEP = 24'(IMG_WORDS);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_IMAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_ARM    = 3'd2,
        S_WAIT   = 3'd3,
        S_OUTPUT = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  index_q, index_d;
    logic [23:0] base_q, base_d;
    logic        done_q, done_d;
    logic        capture_s;

    logic [10:0] xmin_q, xmax_q, ymin_q, ymax_q, w_q, h_q;
    logic [7:0]  ridx_q;
    logic        empty_q;

    logic [10:0] ymin_px_s, ymax_px_s, w_d, h_d;
    logic        empty_d;

    // The engine reports y bounds as byte offsets (3 bytes per pixel).
    function automatic logic [10:0] div3(input logic [10:0] v);
        return v / 11'd3;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic, including the image index/base walk and the done pulse.
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        base_d    = base_q;
        done_d    = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (batch_start) begin
                    state_d = S_ISSUE;
                    index_d = 8'd0;
                    base_d  = 24'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: state_d = S_ARM;
            // eng_done may still reflect the previous image here, so it is not looked at.
            S_ARM:   state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    state_d   = S_OUTPUT;
                    capture_s = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_OUTPUT: begin
                if (res_ready) begin
                    if (index_q < LAST_IDX) begin
                        state_d = S_ISSUE;
                        index_d = index_q + 8'd1;
                        base_d  = base_q + IMG_STEP;
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = S_OUTPUT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Convert raw engine bounds into pixel-unit result fields.
    always_comb begin
        ymin_px_s = div3(eng_yMin);
        ymax_px_s = div3(eng_yMax);
        empty_d   = (eng_xMin > eng_xMax);
        if (empty_d) begin
            w_d = 11'd0;
            h_d = 11'd0;
        end else begin
            w_d = eng_xMax - eng_xMin + 11'd1;
            h_d = ymax_px_s - ymin_px_s + 11'd1;
        end
    end

    // Index, base, done pulse and the result holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_q <= 8'd0;
            base_q  <= 24'd0;
            done_q  <= 1'b0;
            xmin_q  <= 11'd0;
            xmax_q  <= 11'd0;
            ymin_q  <= 11'd0;
            ymax_q  <= 11'd0;
            w_q     <= 11'd0;
            h_q     <= 11'd0;
            ridx_q  <= 8'd0;
            empty_q <= 1'b0;
        end else begin
            index_q <= index_d;
            base_q  <= base_d;
            done_q  <= done_d;
            if (capture_s) begin
                xmin_q  <= eng_xMin;
                xmax_q  <= eng_xMax;
                ymin_q  <= ymin_px_s;
                ymax_q  <= ymax_px_s;
                w_q     <= w_d;
                h_q     <= h_d;
                ridx_q  <= index_q;
                empty_q <= empty_d;
            end
        end
    end

    // Control outputs decoded from the registered state.
    always_comb begin
        batch_busy = 1'b1;
        eng_start  = 1'b0;
        res_valid  = 1'b0;
        case (state_q)
            S_IDLE:   batch_busy = 1'b0;
            S_ISSUE:  eng_start  = 1'b1;
            S_ARM:    batch_busy = 1'b1;
            S_WAIT:   batch_busy = 1'b1;
            S_OUTPUT: res_valid  = 1'b1;
            default:  batch_busy = 1'b0;
        endcase
    end

    assign mem_addr   = base_q + eng_addr;
    assign eng_rddata = mem_rddata;
    assign batch_done = done_q;
    assign res_index  = ridx_q;
    assign res_xMin   = xmin_q;
    assign res_xMax   = xmax_q;
    assign res_yMin   = ymin_q;
    assign res_yMax   = ymax_q;
    assign res_w      = w_q;
    assign res_h      = h_q;
    assign res_empty  = empty_q;

endmodule

// File: doc/bbox_batch_ctrl.md
Name: bbox_batch_ctrl

Overview:
- Sequences one boundingBox engine across a batch of NUM_IMAGES images stored back-to-back in a shared image memory.
- Per image it relocates the engine's read address, starts the engine, waits for its done, and converts the raw bounds to pixel units.
- Results go out over a valid/ready handshake to the downstream crop/classify stage.

Parameters:
- WIDTH, 100, image width in pixels; must match the engine.
- HEIGHT, 100, image height in pixels; must match the engine.
- NUM_IMAGES, 4, images per batch, 1..255.
- IMG_WORDS, WIDTH*HEIGHT*3, bytes per image; image i starts at address i*IMG_WORDS.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- batch_start  in  1  level; sampled only in IDLE
- batch_busy  out  1  high in every state except IDLE
- batch_done  out  1  one-cycle pulse after the last result is accepted
- eng_start  out  1  one-cycle start pulse to the engine
- eng_done  in  1  engine done level
- eng_addr  in  24  engine-relative read address
- eng_xMin, eng_xMax  in  11 each  engine column bounds
- eng_yMin, eng_yMax  in  11 each  engine bounds as byte offsets, multiples of 3
- mem_addr  out  24  shared memory read address
- mem_rddata  in  8  shared memory read data
- eng_rddata  out  8  data to the engine
- res_valid  out  1  result valid
- res_ready  in  1  downstream accept
- res_index  out  8  image number, 0..NUM_IMAGES-1
- res_xMin, res_xMax, res_yMin, res_yMax  out  11 each  bounds in pixels
- res_w, res_h  out  11 each  box width and height in pixels
- res_empty  out  1  no foreground pixel found

Behaviour:
- Reset (async, rst_n=0): state IDLE, index 0, base 0, all outputs 0.
- Datapath, combinational:
  - mem_addr = base + eng_addr (24-bit, no saturation).
  - eng_rddata = mem_rddata.
  - base is registered and equals index*IMG_WORDS. It is updated by adding IMG_WORDS, never by multiplying.
- IDLE:
  - batch_start=1 -> index=0, base=0, go to ISSUE.
  - batch_start=0 -> stay.
- ISSUE: eng_start=1 for exactly this cycle; go to ARM.
- ARM: one cycle in which eng_done is ignored, because it can still show the previous image's done; go to WAIT.
- WAIT: stay while eng_done=0. When eng_done=1, register the result and go to OUTPUT.
- Result computation, registered on the WAIT exit:
  - res_xMin = eng_xMin, res_xMax = eng_xMax.
  - res_yMin = eng_yMin/3, res_yMax = eng_yMax/3.
  - res_empty = (eng_xMin > eng_xMax).
  - If empty: res_w = res_h = 0. Otherwise res_w = xMax-xMin+1 and res_h = yMax/3 - yMin/3 + 1.
  - res_index = index.
- OUTPUT:
  - res_valid=1. All res_* fields are held stable until res_ready=1.
  - Transfer occurs on a cycle with res_valid & res_ready. res_valid drops the following cycle.
  - After transfer, if index < NUM_IMAGES-1: index+1, base+IMG_WORDS, go to ISSUE.
  - After transfer of the last image: batch_done pulses 1 cycle and the block returns to IDLE.
- res_ready held high: back-to-back images have no extra bubble beyond ISSUE and ARM.
- batch_start while busy: ignored. It does not restart or queue a batch.
- batch_start held high through IDLE: a new batch starts the cycle after batch_done.
- Reset mid-batch: immediate return to IDLE, res_valid=0, eng_start=0.
  - The engine is not reset by this block. The next batch's start pulse restarts it from its finished or init state.
- NUM_IMAGES=1: one ISSUE/ARM/WAIT/OUTPUT pass, then batch_done.
- Latency per image: 2 cycles plus engine run time plus 1 cycle to res_valid.

Test Plan:
- Setup for all scenarios: WIDTH=HEIGHT=4, IMG_WORDS=48, NUM_IMAGES=3; engine and memory model attached; image 1 holds one byte of value 200 at relative address 17 (x=1, byte 5), other images hold background -> index0 empty (res_w=0, res_empty=1); index1 xMin=xMax=1, yMin=yMax=1, res_w=res_h=1; mem_addr during image 1 spans 48..95; batch_done pulse follows the 3rd transfer.
- Backpressure: res_ready=0 for 10 cycles at OUTPUT -> res_valid stays 1, fields stable, eng_start not reasserted; transfer on the first ready cycle.
- Stale done: engine done already 1 from a previous batch when ISSUE fires -> ARM ignores it; captured result matches the new image, not stale values.
- batch_start pulsed during WAIT -> no effect; batch still completes with exactly 3 results.
- rst_n asserted in WAIT of image 1 -> outputs 0 asynchronously; a new batch_start restarts at index 0, base 0.
- Full image foreground (all bytes 255) -> res_xMin=0, res_xMax=3, res_yMin=0, res_yMax=3, res_w=res_h=4, res_empty=0.
